// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux scan sequencer slice:
//   - state_t and its IDLE / SCAN / HOLD encodings
//   - NUM_CH / SEL_W channel geometry and the index of the last channel
//   - parity4() helper used when the parity output is built in
// No ports (package).
// -----------------------------------------------------------------------------
package mux_scan_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   // Index of the final channel of a scan; the channel counter stops here.
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   // FSM encoding kept as plain constants so older code can compare raw bits.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t SCAN = 2'd1;
   localparam state_t HOLD = 2'd2;

   // Even-parity helper: XOR of all four captured samples.
   function automatic logic parity4(input logic [NUM_CH-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts how long the current mux channel has been selected. While en is high
// the count advances every clock and tc flags the last cycle of the dwell; the
// count wraps to zero on that cycle so the next channel starts fresh.
// Parameters:
//   DWELL  cycles per channel, 1..255 (anything else stops elaboration)
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   en   in   count enable (high while a scan is running)
//   tc   out  terminal count: current cycle is the last dwell cycle
// -----------------------------------------------------------------------------
module dwell_counter #(
   parameter int DWELL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tc
);

   localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

   generate
      if ((DWELL < 1) || (DWELL > 255)) begin : g_bad_dwell
         $error("dwell_counter: DWELL must be within 1..255");
      end
   endgenerate

   logic [7:0] cnt_r;

   // A one-cycle dwell ends on every cycle, so tc is simply tied high then.
   assign tc = (DWELL == 1) ? 1'b1 : (cnt_r == LAST_CNT);

   // Dwell cycle counter; wraps on terminal count so it is zero at every channel start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= 8'd0;
      end else if (en) begin
         if (tc) begin
            cnt_r <= 8'd0;
         end else begin
            cnt_r <= cnt_r + 8'd1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
// Drives the select lines of an external 4-to-1 mux, dwells DWELL cycles on
// each channel, samples the mux output Y on the last dwell cycle and presents
// the four samples as FRAME with a VALID/READY handshake.
//
// VALID is published one cycle after the final sample is registered, so a
// scan sampled at edge E0 raises VALID at edge E0 + 4*DWELL + 1 and FRAME has
// been stable for a full cycle when VALID is first seen.
//
// Parameters:
//   DWELL  cycles each channel stays selected, 1..255
// Ports:
//   CLK    in      clock, rising edge
//   RST    in      asynchronous active-high reset
//   START  in      request one scan (honoured in IDLE, or in HOLD on hand-off)
//   S0     out     mux select bit 0
//   S1     out     mux select bit 1
//   Y      in      downstream mux output
//   FRAME  out [4] FRAME[n] = Y sampled while channel n was selected
//   VALID  out     FRAME holds a complete scan
//   READY  in      consumer accepts FRAME (only meaningful in HOLD)
//   BUSY   out     scan in progress
//   P      out     XOR of FRAME, only with MUX_SCAN_PARITY_EN defined
//
// Build option: define MUX_SCAN_PARITY_EN to add the parity output P.
// -----------------------------------------------------------------------------
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              S0,
   output logic              S1,
   input  logic              Y,
   output logic [NUM_CH-1:0] FRAME,
   output logic              VALID,
   input  logic              READY,
   output logic              BUSY
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic              P
`endif
);

   state_t            state_r;
   logic [SEL_W-1:0]  ch_r;
   logic [SEL_W-1:0]  sel_r;
   logic [NUM_CH-1:0] frame_r;
   logic              valid_r;
   logic              busy_r;
   logic              commit_r;   // final sample taken, VALID goes up next edge
   logic              dwell_en_s;
   logic              tc_s;
`ifdef MUX_SCAN_PARITY_EN
   logic              p_r;
`endif

   assign dwell_en_s = (state_r == SCAN);

   dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk (CLK),
      .rst (RST),
      .en  (dwell_en_s),
      .tc  (tc_s)
   );

   // Scan sequencing, sample capture and output handshake.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r  <= IDLE;
         ch_r     <= '0;
         sel_r    <= '0;
         frame_r  <= '0;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
         commit_r <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         p_r      <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (START) begin
                  state_r <= SCAN;
                  ch_r    <= '0;
                  sel_r   <= '0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end

            SCAN: begin
               if (tc_s) begin
                  frame_r[ch_r] <= Y;
                  if (ch_r == LAST_CH) begin
                     // Channel counter parks on the last channel; it never wraps mid-scan.
                     state_r  <= HOLD;
                     sel_r    <= '0;
                     busy_r   <= 1'b0;
                     commit_r <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                     p_r      <= parity4({Y, frame_r[NUM_CH-2:0]});
`endif
                  end else begin
                     ch_r  <= ch_r + 2'd1;
                     sel_r <= ch_r + 2'd1;
                  end
               end else begin
                  sel_r <= ch_r;
               end
            end

            HOLD: begin
               if (commit_r) begin
                  commit_r <= 1'b0;
                  valid_r  <= 1'b1;
               end else if (valid_r && READY) begin
                  valid_r <= 1'b0;
                  ch_r    <= '0;
                  sel_r   <= '0;
                  if (START) begin
                     // Back-to-back hand-off: next scan starts with no idle cycle.
                     state_r <= SCAN;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= HOLD;
               end
            end

            default: begin
               state_r  <= IDLE;
               ch_r     <= '0;
               sel_r    <= '0;
               valid_r  <= 1'b0;
               busy_r   <= 1'b0;
               commit_r <= 1'b0;
            end
         endcase
      end
   end

   assign S0    = sel_r[0];
   assign S1    = sel_r[1];
   assign FRAME = frame_r;
   assign VALID = valid_r;
   assign BUSY  = busy_r;
`ifdef MUX_SCAN_PARITY_EN
   assign P     = p_r;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Two sequencers (DWELL=1 and DWELL=3) each scan a modelled 4-to-1 mux.
// Expected frames and VALID arrival cycles are queued when a scan is started
// and checked by a monitor when VALID rises.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

   localparam int DW_A = 1;
   localparam int DW_B = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] start_v = 2'b00;
   logic [1:0] ready_v = 2'b00;
   logic [1:0] sel_lo, sel_hi, valid_v, busy_v, y_v;
   logic [1:0] valid_prev = 2'b00;
   logic [3:0] d_a = 4'b0000;
   logic [3:0] d_b = 4'b0000;
   logic [3:0] frame_a, frame_b;
`ifdef MUX_SCAN_PARITY_EN
   logic [1:0] p_v;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;

   logic [3:0] exp_fr_a[$];
   logic [3:0] exp_fr_b[$];
   int         exp_cyc_a[$];
   int         exp_cyc_b[$];

   always #5 clk = ~clk;

   // Count rising edges so VALID arrival can be checked against the start edge.
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Downstream mux models: Y = D[{S1,S0}].
   assign y_v[0] = d_a[{sel_hi[0], sel_lo[0]}];
   assign y_v[1] = d_b[{sel_hi[1], sel_lo[1]}];

   mux_scan_sequencer #(.DWELL(DW_A)) u_dut_a (
      .CLK   (clk),
      .RST   (rst),
      .START (start_v[0]),
      .S0    (sel_lo[0]),
      .S1    (sel_hi[0]),
      .Y     (y_v[0]),
      .FRAME (frame_a),
      .VALID (valid_v[0]),
      .READY (ready_v[0]),
      .BUSY  (busy_v[0])
`ifdef MUX_SCAN_PARITY_EN
      ,
      .P     (p_v[0])
`endif
   );

   mux_scan_sequencer #(.DWELL(DW_B)) u_dut_b (
      .CLK   (clk),
      .RST   (rst),
      .START (start_v[1]),
      .S0    (sel_lo[1]),
      .S1    (sel_hi[1]),
      .Y     (y_v[1]),
      .FRAME (frame_b),
      .VALID (valid_v[1]),
      .READY (ready_v[1]),
      .BUSY  (busy_v[1])
`ifdef MUX_SCAN_PARITY_EN
      ,
      .P     (p_v[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int dwell_of(input int k);
      return (k == 0) ? DW_A : DW_B;
   endfunction

   function automatic logic [1:0] sel_of(input int k);
      return (k == 0) ? {sel_hi[0], sel_lo[0]} : {sel_hi[1], sel_lo[1]};
   endfunction

   function automatic logic [3:0] frame_of(input int k);
      return (k == 0) ? frame_a : frame_b;
   endfunction

   // Pop the scoreboard entry for a completed scan and compare it.
   task automatic on_valid(input int k);
      logic [3:0] ef;
      int         ec;
      if ((k == 0 && exp_fr_a.size() == 0) || (k == 1 && exp_fr_b.size() == 0)) begin
         chk($sformatf("unexpected_valid_d%0d", k), 32'd1, 32'd0);
      end else begin
         if (k == 0) begin
            ef = exp_fr_a.pop_front();
            ec = exp_cyc_a.pop_front();
         end else begin
            ef = exp_fr_b.pop_front();
            ec = exp_cyc_b.pop_front();
         end
         chk($sformatf("frame_d%0d", k), 32'(frame_of(k)), 32'(ef));
         chk($sformatf("latency_d%0d", k), 32'(cyc_cnt), 32'(ec));
`ifdef MUX_SCAN_PARITY_EN
         chk($sformatf("parity_d%0d", k), 32'(p_v[k]), 32'(^ef));
`endif
      end
   endtask

   // Monitor: every VALID rising edge must match a queued scan.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (valid_v[k] && !valid_prev[k]) on_valid(k);
      end
      valid_prev <= valid_v;
   end

   // Load mux data, queue the expected result and pulse START for one edge.
   task automatic kick(input int k, input logic [3:0] d);
      int ec;
      ec = cyc_cnt + 2 + 4 * dwell_of(k);
      if (k == 0) begin
         d_a = d;
         exp_fr_a.push_back(d);
         exp_cyc_a.push_back(ec);
      end else begin
         d_b = d;
         exp_fr_b.push_back(d);
         exp_cyc_b.push_back(ec);
      end
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
   endtask

   // Called in the cycle after the START edge; walks the select sequence.
   task automatic follow(input int k);
      int dw;
      dw = dwell_of(k);
      for (int ch = 0; ch < 4; ch++) begin
         for (int j = 0; j < dw; j++) begin
            chk("scan_sel", 32'(sel_of(k)), 32'(ch));
            chk("scan_busy", 32'(busy_v[k]), 32'd1);
            chk("scan_valid", 32'(valid_v[k]), 32'd0);
            @(negedge clk);
         end
      end
      chk("done_sel", 32'(sel_of(k)), 32'd0);
      chk("done_busy", 32'(busy_v[k]), 32'd0);
      chk("done_valid", 32'(valid_v[k]), 32'd0);
      @(negedge clk);
      chk("hold_valid", 32'(valid_v[k]), 32'd1);
   endtask

   task automatic release_hold(input int k);
      ready_v[k] = 1'b1;
      @(negedge clk);
      ready_v[k] = 1'b0;
      chk("release_valid", 32'(valid_v[k]), 32'd0);
      chk("release_busy", 32'(busy_v[k]), 32'd0);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_sel", 32'(sel_of(k)), 32'd0);
         chk("rst_frame", 32'(frame_of(k)), 32'd0);
         chk("rst_valid", 32'(valid_v[k]), 32'd0);
         chk("rst_busy", 32'(busy_v[k]), 32'd0);
      end
      rst = 1'b0;

      // DWELL=1, D0..D3 = 1,0,1,1
      kick(0, 4'b1101);
      follow(0);

      // HOLD with READY low: inputs toggle, a START is ignored, FRAME/VALID stay put.
      for (int i = 0; i < 10; i++) begin
         d_a = ~d_a;
         start_v[0] = (i == 4) ? 1'b1 : 1'b0;
         chk("stall_frame", 32'(frame_a), 32'h0000_000d);
         chk("stall_valid", 32'(valid_v[0]), 32'd1);
         chk("stall_busy", 32'(busy_v[0]), 32'd0);
         @(negedge clk);
      end
      start_v[0] = 1'b0;
      release_hold(0);
      @(negedge clk);
      chk("idle_busy", 32'(busy_v[0]), 32'd0);
      chk("idle_sel", 32'(sel_of(0)), 32'd0);

      // DWELL=3, D0..D3 = 0,1,0,0
      kick(1, 4'b0010);
      follow(1);
      release_hold(1);

      // READY held high throughout a scan: no effect until HOLD, then VALID lasts one cycle.
      ready_v[1] = 1'b1;
      kick(1, 4'b1001);
      follow(1);
      @(negedge clk);
      chk("ready_hi_valid", 32'(valid_v[1]), 32'd0);
      chk("ready_hi_busy", 32'(busy_v[1]), 32'd0);
      ready_v[1] = 1'b0;

      // Parity frames, second one started on the same edge that accepts the first.
      kick(0, 4'b0111);
      follow(0);
      ready_v[0] = 1'b1;
      kick(0, 4'b1111);
      ready_v[0] = 1'b0;
      follow(0);
      release_hold(0);

      // Reset while channel 2 is selected aborts the scan.
      kick(0, 4'b1010);
      @(negedge clk);
      @(negedge clk);
      chk("pre_abort_sel", 32'(sel_of(0)), 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("abort_sel", 32'(sel_of(0)), 32'd0);
      chk("abort_frame", 32'(frame_a), 32'd0);
      chk("abort_valid", 32'(valid_v[0]), 32'd0);
      chk("abort_busy", 32'(busy_v[0]), 32'd0);
      void'(exp_fr_a.pop_back());
      void'(exp_cyc_a.pop_back());
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_abort_valid", 32'(valid_v[0]), 32'd0);
      chk("post_abort_busy", 32'(busy_v[0]), 32'd0);

      // START on the very first edge after reset release.
      rst = 1'b1;
      #2 rst = 1'b0;
      kick(0, 4'b0110);
      follow(0);
      release_hold(0);

      repeat (3) @(negedge clk);
      chk("sb_a_empty", 32'(exp_fr_a.size()), 32'd0);
      chk("sb_b_empty", 32'(exp_fr_b.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
